sd_bus_arbiter: RTL



---
 rtl/sd_pkg.sv | 24 ++
 rtl/sd_bus_arbiter_if.sv | 15 +
 rtl/sd_bus_arbiter_chk.sv | 15 +
 rtl/sd_rr_pick.sv | 31 +++
 rtl/sd_bus_arbiter.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/sd_pkg.sv
// Shared constants and types for the SD card SPI bus arbiter: requester
// indices, FSM state encoding and default timing parameters.
package sd_pkg;

   localparam int NUM_REQ  = 3;
   localparam int REQ_INIT = 0;
   localparam int REQ_RD   = 1;
   localparam int REQ_WR   = 2;

   localparam int GAP_CYC_DEF     = 8;
   localparam int TIMEOUT_CYC_DEF = 65536;
   localparam int CNT_W_DEF       = 17;

   // Round-robin pointer encoding: which of read/write is preferred next
   localparam logic RR_RD = 1'b0;
   localparam logic RR_WR = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } arb_state_e;

endpackage

// File: rtl/sd_bus_arbiter_if.sv
// Requester-side handshake bundle of the SD bus arbiter: request, done,
// per-requester pin drives and the one-hot grant returned by the arbiter.
interface sd_bus_arbiter_if;
   import sd_pkg::*;

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] done;
   logic [NUM_REQ-1:0] mosi_in;
   logic [NUM_REQ-1:0] csn_in;
   logic [NUM_REQ-1:0] gnt;

   modport master (output req, output done, output mosi_in, output csn_in, input gnt);
   modport slave  (input req, input done, input mosi_in, input csn_in, output gnt);

endinterface

// File: rtl/sd_bus_arbiter_chk.sv
// Simulation checker for the arbiter: the grant vector may never have more
// than one bit set.
module sd_bus_arbiter_chk
   import sd_pkg::*;
(
   input logic               clk,
   input logic               rst_n,
   input logic [NUM_REQ-1:0] gnt
);

   // Grant must be one-hot or zero whenever out of reset
   a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt))
      else $error("sd_bus_arbiter: grant not one-hot, gnt=%b", gnt);

endmodule

// File: rtl/sd_rr_pick.sv
// Combinational winner select: init beats everything, read and write
// alternate according to rr_ptr when both are eligible.
module sd_rr_pick
   import sd_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_m,
   input  logic               rr_ptr,
   output logic [NUM_REQ-1:0] win
);

   // Fixed priority for init, round-robin tie-break between read and write
   always_comb begin
      win = {NUM_REQ{1'b0}};
      if (req_m[REQ_INIT]) begin
         win[REQ_INIT] = 1'b1;
      end else if (req_m[REQ_RD] && req_m[REQ_WR]) begin
         if (rr_ptr == RR_WR) begin
            win[REQ_WR] = 1'b1;
         end else begin
            win[REQ_RD] = 1'b1;
         end
      end else if (req_m[REQ_RD]) begin
         win[REQ_RD] = 1'b1;
      end else if (req_m[REQ_WR]) begin
         win[REQ_WR] = 1'b1;
      end else begin
         win = {NUM_REQ{1'b0}};
      end
   end

endmodule

// File: rtl/sd_bus_arbiter.sv
// SPI bus arbiter for the SD card: grants one of init/read/write engines,
// enforces an idle gap between owners and releases a stuck owner by watchdog.
module sd_bus_arbiter
   import sd_pkg::*;
#(
   parameter int GAP_CYC     = GAP_CYC_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int CNT_W       = CNT_W_DEF
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             init_ok,
   sd_bus_arbiter_if.slave  bus,
   output logic             SD_MOSI,
   output logic             SD_CSn,
   output logic             busy,
   output logic             timeout_err
);

   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   arb_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic               rr_ptr_q, rr_ptr_d;
   logic               timeout_err_q, timeout_err_d;

   logic [NUM_REQ-1:0] req_m;
   logic [NUM_REQ-1:0] win;
   logic               owner_done;
   logic               owner_req;

   // Read and write may only compete once the card is initialised
   assign req_m = {bus.req[REQ_WR] & init_ok, bus.req[REQ_RD] & init_ok, bus.req[REQ_INIT]};

   // Only the current owner's done/req matter; everyone else is ignored
   assign owner_done = |(bus.done & gnt_q);
   assign owner_req  = |(bus.req & gnt_q);

   sd_rr_pick u_pick (
      .req_m  (req_m),
      .rr_ptr (rr_ptr_q),
      .win    (win)
   );

   // Next-state, counter, grant and round-robin pointer logic
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      gnt_d         = gnt_q;
      rr_ptr_d      = rr_ptr_q;
      timeout_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req_m) begin
               state_d = GRANT;
               gnt_d   = win;
               cnt_d   = {CNT_W{1'b0}};
               if (win[REQ_RD]) begin
                  rr_ptr_d = RR_WR;
               end else if (win[REQ_WR]) begin
                  rr_ptr_d = RR_RD;
               end else begin
                  rr_ptr_d = rr_ptr_q;
               end
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            // done has precedence over the watchdog in the same cycle
            if (owner_done || !owner_req) begin
               state_d = GAP;
               gnt_d   = {NUM_REQ{1'b0}};
               cnt_d   = {CNT_W{1'b0}};
            end else if (cnt_q == TO_LAST) begin
               state_d       = GAP;
               gnt_d         = {NUM_REQ{1'b0}};
               cnt_d         = {CNT_W{1'b0}};
               timeout_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = IDLE;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = {NUM_REQ{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= {CNT_W{1'b0}};
         gnt_q         <= {NUM_REQ{1'b0}};
         rr_ptr_q      <= RR_RD;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         gnt_q         <= gnt_d;
         rr_ptr_q      <= rr_ptr_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Pin mux: owner drives the card in GRANT, idle-high otherwise
   always_comb begin
      if (state_q == GRANT) begin
         SD_MOSI = |(bus.mosi_in & gnt_q);
         SD_CSn  = |(bus.csn_in & gnt_q);
      end else begin
         SD_MOSI = 1'b1;
         SD_CSn  = 1'b1;
      end
   end

   assign bus.gnt     = gnt_q;
   assign busy        = (state_q != IDLE);
   assign timeout_err = timeout_err_q;

   sd_bus_arbiter_chk u_chk (
      .clk   (clk),
      .rst_n (rst_n),
      .gnt   (gnt_q)
   );

endmodule
